// File: rtl/click_classifier.sv
// Groups debounced press pulses into bursts and emits one registered
// single/double/triple classification pulse per burst.
module click_classifier #(
   parameter int WINDOW = 50,
   parameter int TMR_W  = 16
) (
   input  logic       sclock,
   input  logic       reset,
   input  logic       press,
   output logic       single_click,
   output logic       double_click,
   output logic       triple_click,
   output logic [1:0] click_count,
   output logic       busy
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);

   state_t           state, state_n;
   logic [1:0]       cnt, cnt_n;
   logic [TMR_W-1:0] tmr, tmr_n;
   logic             sgl_n, dbl_n, tpl_n;
   logic [1:0]       cc_n;

   always_ff @(posedge sclock) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         tmr          <= '0;
         single_click <= 1'b0;
         double_click <= 1'b0;
         triple_click <= 1'b0;
         click_count  <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         tmr          <= tmr_n;
         single_click <= sgl_n;
         double_click <= dbl_n;
         triple_click <= tpl_n;
         click_count  <= cc_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tmr_n   = tmr;
      sgl_n   = 1'b0;
      dbl_n   = 1'b0;
      tpl_n   = 1'b0;
      cc_n    = click_count;
      case (state)
         IDLE: begin
            tmr_n = '0;
            if (press) begin
               cnt_n   = 2'd1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            // A press on the last window cycle still extends the burst.
            if (press) begin
               cnt_n = cnt + 2'd1;
               tmr_n = '0;
               if (cnt == 2'd2) begin
                  tpl_n   = 1'b1;
                  cc_n    = 2'd3;
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end else if (tmr == TMR_LAST) begin
               sgl_n   = (cnt == 2'd1);
               dbl_n   = (cnt == 2'd2);
               cc_n    = cnt;
               cnt_n   = '0;
               tmr_n   = '0;
               state_n = IDLE;
            end else begin
               tmr_n = tmr + TMR_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State is a flop, so busy is registered and already low in the pulse cycle.
   assign busy = (state == WAIT);

endmodule

// File: tb/tb_click_classifier.sv
// Directed plus random bench for click_classifier; expected outputs come from
// a burst model based on press times rather than a timer.
module tb_click_classifier;

   localparam int WINDOW = 8;

   logic       sclock = 1'b0;
   logic       reset  = 1'b1;
   logic       press  = 1'b0;
   logic       single_click, double_click, triple_click, busy;
   logic [1:0] click_count;

   int vectors = 0;
   int miscompares = 0;

   // model state
   int         t = 0;
   bit         open = 1'b0;
   int         n = 0;
   int         last = 0;
   logic [5:0] exp_o = '0;
   logic [1:0] exp_cc = '0;

   click_classifier #(.WINDOW(WINDOW), .TMR_W(16)) dut (
      .sclock(sclock), .reset(reset), .press(press),
      .single_click(single_click), .double_click(double_click),
      .triple_click(triple_click), .click_count(click_count), .busy(busy)
   );

   always #5 sclock = ~sclock;

   task automatic model(input bit p, input bit r);
      logic s, d, tr;
      s = 0; d = 0; tr = 0;
      if (r) begin
         open = 0; n = 0; exp_cc = 0;
      end else if (!open) begin
         if (p) begin open = 1; n = 1; last = t; end
      end else if (p) begin
         n++; last = t;
         if (n == 3) begin tr = 1; exp_cc = 2'd3; open = 0; end
      end else if (t - last == WINDOW) begin
         s = (n == 1); d = (n == 2); exp_cc = 2'(n); open = 0;
      end
      exp_o = {s, d, tr, exp_cc, open};
      t++;
   endtask

   task automatic step(input bit p, input bit r, input string tag);
      logic [5:0] obs;
      @(negedge sclock);
      press = p; reset = r;
      @(posedge sclock);
      model(p, r);
      #1;
      obs = {single_click, double_click, triple_click, click_count, busy};
      vectors++;
      assert (obs === exp_o) else begin
         miscompares++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp_o);
      end
   endtask

   task automatic idle(input int k, input string tag);
      for (int i = 0; i < k; i++) step(1'b0, 1'b0, tag);
   endtask

   initial begin
      step(0, 1, "reset");
      step(0, 1, "reset");
      idle(2, "quiet");
      // single
      step(1, 0, "single");
      idle(10, "single");
      // double at E0, E5
      step(1, 0, "double"); idle(4, "double"); step(1, 0, "double");
      idle(10, "double");
      // triple at E0, E3, E6
      step(1, 0, "triple"); idle(2, "triple"); step(1, 0, "triple");
      idle(2, "triple"); step(1, 0, "triple");
      idle(3, "triple");
      // boundary E0/E8 extends, E0/E9 splits
      step(1, 0, "bound8"); idle(7, "bound8"); step(1, 0, "bound8");
      idle(10, "bound8");
      step(1, 0, "bound9"); idle(8, "bound9"); step(1, 0, "bound9");
      idle(10, "bound9");
      // reset mid-burst, then a fresh single
      step(1, 0, "midrst"); idle(3, "midrst"); step(0, 1, "midrst");
      step(1, 0, "midrst"); idle(10, "midrst");
      // reset wins over press
      step(1, 1, "rstpress"); idle(3, "rstpress");
      // held press
      step(1, 0, "held"); step(1, 0, "held"); step(1, 0, "held");
      idle(2, "held");
      // press during single pulse cycle opens new burst
      step(1, 0, "pulsepress"); idle(7, "pulsepress");
      idle(1, "pulsepress");
      step(1, 0, "pulsepress");
      idle(10, "pulsepress");
      // random
      for (int i = 0; i < 3000; i++) begin
         bit p, r;
         p = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 12 : 40));
         r = ($urandom_range(0, 299) == 0);
         step(p, r, "random");
      end
      idle(12, "drain");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
